// File: rtl/bsg_manycore_sdr_upstream_tx.sv
// ---------------------------------------------------------------------------
// bsg_manycore_sdr_upstream_tx
//
// Transmit end of one SDR link channel (fwd or rev). Packets arrive from the
// core on a valid/ready_and interface and leave on registered link valid/data
// wires. Sending is gated by a credit counter. The counter starts at the
// receiver FIFO depth and loses one credit per packet sent. It gains
// 2^lg_credit_to_token_decimation_p credits for every rising edge the
// receiver drives on the token wire. Link and core share clk_i.
//
// Parameters
//   width_p                          packet width
//   lg_fifo_depth_p                  log2 of receiver FIFO depth (max credits)
//   lg_credit_to_token_decimation_p  log2 of credits returned per token edge
//                                    (must be <= lg_fifo_depth_p)
//
// Ports
//   clk_i           in   clock shared by core and link
//   reset_i         in   synchronous, active-high reset
//   disable_i       in   blocks sending; token edges are still counted
//   data_i          in   core packet
//   v_i             in   core packet valid
//   ready_and_o     out  transmitter can accept (credits left, enabled)
//   link_data_o     out  registered link data (holds when idle)
//   link_v_o        out  registered link valid
//   link_token_i    in   token wire from receiver, one token per 0->1 edge
//   credit_count_o  out  current credit count, 0..2^lg_fifo_depth_p
//   overflow_o      out  sticky: credits would have exceeded the maximum
// ---------------------------------------------------------------------------

module bsg_manycore_sdr_upstream_tx
  #(parameter int width_p                         = 8
  , parameter int lg_fifo_depth_p                 = 3
  , parameter int lg_credit_to_token_decimation_p = 1
  )
  ( input  logic                       clk_i
  , input  logic                       reset_i
  , input  logic                       disable_i

  , input  logic [width_p-1:0]         data_i
  , input  logic                       v_i
  , output logic                       ready_and_o

  , output logic [width_p-1:0]         link_data_o
  , output logic                       link_v_o
  , input  logic                       link_token_i

  , output logic [lg_fifo_depth_p:0]   credit_count_o
  , output logic                       overflow_o
  );

    localparam int cw_lp = lg_fifo_depth_p + 1;
    // One extra bit so a full counter plus a token return cannot wrap.
    localparam int ew_lp = lg_fifo_depth_p + 2;

    localparam logic [ew_lp-1:0] max_credits_lp = ew_lp'(1) << lg_fifo_depth_p;
    localparam logic [ew_lp-1:0] token_inc_lp   = ew_lp'(1) << lg_credit_to_token_decimation_p;

    logic [cw_lp-1:0]   credits_r;
    logic               overflow_r;
    logic               link_v_r;
    logic [width_p-1:0] link_data_r;
    logic               tok_r1;
    logic               tok_r2;

    logic               send;
    logic               token_edge;
    logic [ew_lp-1:0]   credits_sum;
    logic               credits_over;

    // ready_and_o never looks at v_i, so the core can wait on it safely.
    assign ready_and_o = (credits_r != '0) & ~disable_i & ~reset_i;
    assign send        = v_i & ready_and_o;
    assign token_edge  = tok_r1 & ~tok_r2;

    // send is only possible with credits_r != 0, so the subtraction never
    // underflows; the widened sum exposes any excess above the FIFO depth.
    assign credits_sum  = {1'b0, credits_r}
                        - ew_lp'(send)
                        + (token_edge ? token_inc_lp : '0);
    assign credits_over = (credits_sum > max_credits_lp);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            // Both synchronizer stages load the live wire so that a token
            // held high across reset release does not look like an edge.
            tok_r1 <= link_token_i;
            tok_r2 <= link_token_i;
        end else begin
            tok_r1 <= link_token_i;
            tok_r2 <= tok_r1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credits_r  <= max_credits_lp[cw_lp-1:0];
            overflow_r <= 1'b0;
        end else if (credits_over) begin
            credits_r  <= max_credits_lp[cw_lp-1:0];
            overflow_r <= 1'b1;
        end else begin
            credits_r  <= credits_sum[cw_lp-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            link_v_r    <= 1'b0;
            link_data_r <= '0;
        end else begin
            link_v_r <= send;
            if (send)
                link_data_r <= data_i;
        end
    end

    assign link_v_o       = link_v_r;
    assign link_data_o    = link_data_r;
    assign credit_count_o = credits_r;
    assign overflow_o     = overflow_r;

endmodule

// File: tb/tb_bsg_manycore_sdr_upstream_tx.sv
module tb_bsg_manycore_sdr_upstream_tx;

    logic       clk;
    logic       reset_i;
    logic       disable_i;
    logic [7:0] data_i;
    logic       v_i;
    logic       ready_and_o;
    logic [7:0] link_data_o;
    logic       link_v_o;
    logic       link_token_i;
    logic [3:0] credit_count_o;
    logic       overflow_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    bsg_manycore_sdr_upstream_tx #(
        .width_p(8),
        .lg_fifo_depth_p(3),
        .lg_credit_to_token_decimation_p(1)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .disable_i(disable_i),
        .data_i(data_i),
        .v_i(v_i),
        .ready_and_o(ready_and_o),
        .link_data_o(link_data_o),
        .link_v_o(link_v_o),
        .link_token_i(link_token_i),
        .credit_count_o(credit_count_o),
        .overflow_o(overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every link beat must match the oldest expected packet.
    always @(negedge clk) begin
        if (link_v_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_packet: got %0h expected none at %0t", link_data_o, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (link_data_o !== e) begin
                    errors++;
                    $display("FAIL packet_data: got %0h expected %0h at %0t", link_data_o, e, $time);
                end
            end
        end
    end

    // Called at posedge+1 with inputs already set; returns at the next posedge+1.
    task automatic step(output bit hs);
        logic [7:0] d;
        #1;
        hs = v_i & ready_and_o;
        d  = data_i;
        if (hs) exp_q.push_back(d);
        @(posedge clk);
        #1;
        check("link_v_latency", link_v_o, hs);
        if (hs) check("link_data_latency", link_data_o, d);
    endtask

    task automatic token_pulse();
        bit hs;
        link_token_i = 1'b1;
        step(hs);
        link_token_i = 1'b0;
        step(hs);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit hs;
        int sent;

        reset_i = 1'b1; disable_i = 1'b0; v_i = 1'b0; data_i = 8'h00; link_token_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready_and_o, 0);
        check("rst_link_v", link_v_o, 0);
        check("rst_link_data", link_data_o, 0);
        check("rst_credits", credit_count_o, 8);
        check("rst_overflow", overflow_o, 0);
        reset_i = 1'b0;
        step(hs);
        check("post_rst_ready", ready_and_o, 1);

        // Burst with no tokens: exactly 8 packets go out.
        sent = 0; v_i = 1'b1; data_i = 8'h01;
        for (int i = 0; i < 14; i++) begin
            step(hs);
            if (hs) begin sent++; data_i = data_i + 8'h01; end
        end
        check("burst_count", sent, 8);
        check("burst_credits", credit_count_o, 0);
        check("burst_ready", ready_and_o, 0);
        check("burst_held_data", data_i, 8'h09);

        // One token edge from zero credits.
        link_token_i = 1'b1;
        step(hs);
        check("tok_n1_credits", credit_count_o, 0);
        check("tok_n1_ready", ready_and_o, 0);
        step(hs);
        check("tok_n2_credits", credit_count_o, 2);
        check("tok_n2_ready", ready_and_o, 1);
        step(hs);
        check("send_09", hs, 1);
        data_i = 8'h0A;
        step(hs);
        check("send_0a", hs, 1);
        v_i = 1'b0;
        check("tok_drain_credits", credit_count_o, 0);
        check("tok_drain_ready", ready_and_o, 0);
        link_token_i = 1'b0;
        step(hs);
        step(hs);

        // Build to 6, spend one to 5, then token edge together with a send.
        token_pulse(); token_pulse(); token_pulse();
        check("pulses_credits", credit_count_o, 6);
        v_i = 1'b1; data_i = 8'h20;
        step(hs);
        v_i = 1'b0;
        check("credits_5", credit_count_o, 5);
        link_token_i = 1'b1;
        step(hs);
        v_i = 1'b1; data_i = 8'h21; link_token_i = 1'b0;
        step(hs);
        check("simul_hs", hs, 1);
        v_i = 1'b0;
        check("simul_credits", credit_count_o, 6);

        // Saturation and sticky overflow.
        token_pulse();
        check("full_credits", credit_count_o, 8);
        check("full_no_overflow", overflow_o, 0);
        token_pulse();
        check("sat_credits", credit_count_o, 8);
        check("sat_overflow", overflow_o, 1);
        repeat (3) step(hs);
        check("overflow_sticky", overflow_o, 1);

        // Disable while sending with 4 credits.
        v_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_i = 8'h30 + 8'(i);
            step(hs);
        end
        data_i = 8'h34;
        check("pre_dis_credits", credit_count_o, 4);
        disable_i = 1'b1;
        #1;
        check("dis_ready_now", ready_and_o, 0);
        step(hs);
        token_pulse();
        check("dis_tok_credits", credit_count_o, 6);
        check("dis_tok_ready", ready_and_o, 0);
        disable_i = 1'b0;
        sent = 0;
        for (int i = 0; i < 10; i++) begin
            step(hs);
            if (hs) begin sent++; data_i = data_i + 8'h01; end
        end
        v_i = 1'b0;
        check("resume_count", sent, 6);
        check("resume_credits", credit_count_o, 0);

        // Token held high across reset release: no edge from it.
        reset_i = 1'b1; link_token_i = 1'b1;
        step(hs); step(hs);
        check("rst2_credits", credit_count_o, 8);
        reset_i = 1'b0;
        v_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_i = 8'h50 + 8'(i);
            step(hs);
        end
        v_i = 1'b0;
        step(hs); step(hs);
        check("held_tok_credits", credit_count_o, 5);
        check("held_tok_overflow", overflow_o, 0);
        link_token_i = 1'b0;
        step(hs); step(hs);
        link_token_i = 1'b1;
        step(hs); step(hs);
        check("later_rise_credits", credit_count_o, 7);
        step(hs); step(hs);
        check("one_edge_only", credit_count_o, 7);

        // Reset mid-burst.
        v_i = 1'b1; data_i = 8'h60;
        step(hs);
        data_i = 8'h61;
        step(hs);
        reset_i = 1'b1;
        #1;
        check("midrst_ready", ready_and_o, 0);
        step(hs);
        check("midrst_link_v", link_v_o, 0);
        check("midrst_credits", credit_count_o, 8);
        v_i = 1'b0; reset_i = 1'b0;
        step(hs);
        check("after_rst_ready", ready_and_o, 1);
        check("after_rst_overflow", overflow_o, 0);
        step(hs); step(hs);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
